ring_osc_freq_meter: RTL



---
 rtl/ring_osc_pkg.sv | 26 ++
 rtl/osc_edge_sync.sv | 36 +++
 rtl/ring_osc_freq_meter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared types and gate-length helper for the ring oscillator frequency meter
package ring_osc_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meter_state_e;

    // Shortest gate window is 2^GATE_MIN_LOG2_DEF clk cycles by default
    localparam int GATE_MIN_LOG2_DEF = 8;

    // gate_sel is 3 bits, so the longest gate is 2^(min_log2+7) cycles
    localparam int GATE_SEL_W    = 3;
    localparam int GATE_SEL_SPAN = 7;

    // Number of clk cycles in the gate window, minus one (initial gate counter value)
    function automatic logic [31:0] gate_len_m1(input int min_log2, input logic [GATE_SEL_W-1:0] sel);
        logic [31:0] len;
        len = 32'd1 << (min_log2 + int'(sel));
        return len - 32'd1;
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - synchroniser and rising-edge detector for an asynchronous oscillator tap
module osc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift the raw input through the synchroniser chain; prev trails the chain output by one clk
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history flops, cleared on reset so no spurious edge follows release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // At most one rise pulse per clk; inputs at or above clk/2 alias silently
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// rtl/ring_osc_freq_meter.sv - gated edge counter measuring an asynchronous oscillator against clk
module ring_osc_freq_meter
    import ring_osc_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int GATE_MIN_LOG2 = GATE_MIN_LOG2_DEF,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  osc_in,
    input  logic                  start,
    input  logic                  cont,
    input  logic [GATE_SEL_W-1:0] gate_sel,
    input  logic [1:0]            byte_sel,
    output logic [7:0]            data_out,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  overflow
);

    // Gate counter must hold 2^(GATE_MIN_LOG2+7)-1
    localparam int          GATE_W  = GATE_MIN_LOG2 + GATE_SEL_SPAN;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    meter_state_e      state_q, state_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic              overflow_q, overflow_d;

    logic              rise;
    logic [31:0]       gate_init;
    logic [CNT_W-1:0]  edge_next;
    logic              sat_next;
    logic [31:0]       result_ext;

    osc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (osc_in),
        .rise     (rise)
    );

    // Initial gate counter value derived from the live gate_sel; only consumed in ARM
    always_comb begin
        gate_init = gate_len_m1(GATE_MIN_LOG2, gate_sel);
    end

    // Saturating edge count including the current cycle's rise
    always_comb begin
        edge_next = edge_cnt_q;
        sat_next  = sat_q;
        if (rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                edge_next = edge_cnt_q + 1'b1;
            end
        end
    end

    // Next-state and datapath for the IDLE/ARM/MEASURE/DONE sequencer
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        gate_cnt_d = gate_cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                gate_cnt_d = gate_init[GATE_W-1:0];
                state_d    = MEASURE;
            end
            MEASURE: begin
                edge_cnt_d = edge_next;
                sat_d      = sat_next;
                if (gate_cnt_q == '0) begin
                    // Capture on the way into DONE so result is already valid while result_valid is high
                    result_d   = edge_next;
                    overflow_d = sat_next;
                    state_d    = DONE;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (cont || start) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer, counters and result registers; reset abandons any measurement in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            gate_cnt_q <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            gate_cnt_q <= gate_cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy         = (state_q == ARM) || (state_q == MEASURE);
        result_valid = (state_q == DONE);
        overflow     = overflow_q;
    end

    // Byte-wise readout; bytes above CNT_W read as zero
    always_comb begin
        result_ext              = '0;
        result_ext[CNT_W-1:0]   = result_q;
        case (byte_sel)
            2'd0:    data_out = result_ext[7:0];
            2'd1:    data_out = result_ext[15:8];
            2'd2:    data_out = result_ext[23:16];
            default: data_out = result_ext[31:24];
        endcase
    end

endmodule
